mem_bus_master: RTL

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_bus_master.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-to-async-RAM bus master: widths, the default
// RAM depth, the FSM state encoding and the address range check.
package mem_bus_pkg;

    localparam int ADDR_W            = 8;
    localparam int DATA_W            = 8;
    localparam int MEM_DEPTH_DEFAULT = 65;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return 32'(addr) < $unsigned(depth);
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Single-request CPU bus master for an asynchronous RAM with a shared
// tristate data bus. Request and response each use a valid/ready pair.
import mem_bus_pkg::*;

module mem_bus_master #(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] mem_data,
    output state_e            dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; request fields are only meaningful while req_valid is high, and
    // the response fields are held stable for as long as rsp_valid is high.

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_oe_q, mem_oe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                accept;
    logic                in_range;

    assign accept   = req_valid && (state_q == ST_IDLE);
    assign in_range = addr_in_range(req_addr, MEM_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range)   state_d = ST_RESP;
                    else if (req_we) state_d = ST_WR;
                    else             state_d = ST_RD_ADDR;
                end
            end
            ST_WR:      state_d = ST_RESP;
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so they are registered
    // and line up exactly with the state they belong to.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        mem_we_d   = (state_d == ST_WR);
        mem_oe_d   = (state_d == ST_RD_DATA);
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (accept) begin
            rdata_d = '0;
            err_d   = !in_range;
            wdata_d = req_wdata;
            if (in_range) mem_addr_d = req_addr;
        end
        if (state_q == ST_RD_DATA) rdata_d = mem_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_oe_q   <= mem_oe_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_data    = mem_we_q ? wdata_q : {DATA_W{1'bz}};
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_oe      = mem_oe_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule
